// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial WIDTH-bit subtractor controller that drives an
//               external single-bit full_subtractor cell, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_c,
    input  logic             fs_diff,
    input  logic             fs_borrow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] w_d_next;

    // Result bits enter at the top so the LSB ends up in bit 0 after WIDTH shifts
    assign w_d_next = {fs_diff, d_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        fs_a    = 1'b0;
        fs_b    = 1'b0;
        fs_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                fs_a   = a_sh_q[0];
                fs_b   = b_sh_q[0];
                fs_c   = brw_q;
                d_sh_d = w_d_next;
                brw_d  = fs_borrow;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == c_last_bit) begin
                    diff_d  = w_d_next;
                    bout_d  = fs_borrow;
                    // Overflow only possible when operand signs differ
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtraction controller built around the team's single-bit full_subtractor cell; the cell itself sits outside this block.
- Latches two WIDTH-bit operands and a borrow-in, then drives the cell one bit per cycle, LSB first, through the fs_* ports.
- Each cycle it captures the cell's difference and borrow, and on completion presents the difference, borrow-out and a signed-overflow flag with a start/busy/done handshake.
- Used wherever a narrow-area multi-bit subtract is needed without instantiating WIDTH cells.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- CW, 4, counter width; must satisfy 2**CW >= WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- fs_a  output  1  to cell minuend bit
- fs_b  output  1  to cell subtrahend bit
- fs_c  output  1  to cell borrow-in
- fs_diff  input  1  from cell difference (combinational, same cycle)
- fs_borrow  input  1  from cell borrow-out (combinational, same cycle)
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result a - b - bin, modulo 2**WIDTH
- bout  output  1  final borrow (unsigned a < b + bin)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset (asserted at any time, including mid-operation): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift registers, borrow register and counter cleared. Any operation in progress is abandoned, with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - a_sh<=a, b_sh<=b, brw<=bin, cnt<=0
  - latch a[WIDTH-1] and b[WIDTH-1] for the overflow calculation
  - go to RUN; busy=1 from that edge.
- IDLE, start=0: hold; diff/bout/ovf keep the previous result.
- RUN, each cycle (combinational outputs):
  - fs_a=a_sh[0], fs_b=b_sh[0], fs_c=brw.
- RUN, at each edge:
  - d_sh<={fs_diff, d_sh[WIDTH-1:1]}
  - brw<=fs_borrow
  - a_sh and b_sh shift right by one, zero-filled
  - cnt<=cnt+1.
- RUN exit: at the edge where cnt==WIDTH-1 (the MSB is processed):
  - diff<=final d_sh; bout<=fs_borrow
  - ovf<=(a_msb != b_msb) && (fs_diff != a_msb)
  - go to DONE; busy=0, done=1.
- DONE: lasts exactly one cycle, then the next edge returns to IDLE with done=0.
- Latency: start accepted at edge E0 -> done high for the cycle following edge E0+WIDTH. Total WIDTH+1 cycles from acceptance to return to IDLE.
- fs_a/fs_b/fs_c are 0 in IDLE and DONE.
- start is ignored in RUN and DONE; there is no queueing. A start held high through DONE is accepted on the first IDLE cycle (back-to-back throughput = one op per WIDTH+2 cycles).
- The a, b and bin inputs may change freely after acceptance without affecting the operation.
- diff, bout and ovf update only at the RUN->DONE edge; they are stable otherwise, including during a later RUN.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start 1 cycle -> busy 8 cycles; done pulse 1 cycle at E0+8; diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. During RUN, fs_c equals the previous cycle's fs_borrow.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0. Change a/b inputs mid-RUN -> result unchanged.
- Pulse start again during RUN and during DONE -> ignored, no extra done. Then hold start high continuously -> ops complete back-to-back every 10 cycles.
- Assert rst at the 4th RUN cycle -> immediately IDLE; busy=0, diff=0, fs_*=0, no done. The next start after rst release produces the correct result.
